// File: rtl/instruction_decoder_v2_pkg.sv
// Shared definitions for the byte-serial GPU command decoder: opcodes,
// FSM state encoding and a helper for field byte counts.
package instruction_decoder_v2_pkg;

   localparam logic [7:0] OP_NOOP         = 8'h00;
   localparam logic [7:0] OP_SET_MODE     = 8'h01;
   localparam logic [7:0] OP_SET_BG_COLOR = 8'h02;
   localparam logic [7:0] OP_SET_PIXEL    = 8'h03;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARGS  = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   // Number of little-endian bytes needed to carry a field of the given width.
   function automatic int bytes_for(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/instruction_decoder_v2_collector.sv
// Argument byte collector: shifts argument bytes into a buffer, counts them
// and times the gap between bytes of one instruction.
module instruction_decoder_v2_collector
   import instruction_decoder_v2_pkg::*;
#(
   parameter int MAXB    = 6,
   parameter int CNTW    = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_active,
   input  logic              i_shift,
   input  logic [7:0]        i_data,
   input  logic [CNTW-1:0]   i_needed,
   output logic              o_full,
   output logic              o_timeout,
   output logic [MAXB*8-1:0] o_buf_next
);

   localparam int TW = $clog2(TIMEOUT);

   logic [MAXB*8-1:0] arg_buf;
   logic [CNTW-1:0]   count;
   logic [TW-1:0]     timer;

   // Newest byte enters at the top, so after a full instruction the first
   // argument byte sits at the bottom and a short instruction sits at the top.
   assign o_buf_next = {i_data, arg_buf[MAXB*8-1:8]};
   assign o_full     = i_shift && ((count + CNTW'(1)) == i_needed);
   assign o_timeout  = i_active && !i_shift && (timer == TW'(TIMEOUT - 1));

   // Buffer, count and timer are held cleared whenever no instruction is collecting.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         arg_buf <= '0;
         count   <= '0;
         timer   <= '0;
      end else if (!i_active) begin
         arg_buf <= '0;
         count   <= '0;
         timer   <= '0;
      end else if (i_shift) begin
         arg_buf <= o_buf_next;
         count   <= count + CNTW'(1);
         timer   <= '0;
      end else begin
         timer   <= timer + TW'(1);
      end
   end

endmodule

// File: rtl/instruction_decoder_v2.sv
// Byte-serial GPU command decoder: collects opcode + little-endian argument
// bytes from the host and issues mode / pixel commands with valid/ready.
module instruction_decoder_v2
   import instruction_decoder_v2_pkg::*;
#(
   parameter int XW       = 10,
   parameter int YW       = 10,
   parameter int CW       = 12,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int TIMEOUT  = 1024
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_we,
   input  logic          i_en,
   input  logic [7:0]    i_data,
   output logic          o_ack,
   output logic          o_busy,
   output logic [7:0]    o_mode,
   output logic          o_set_mode,
   input  logic          i_mode_ready,
   output logic [XW-1:0] o_pixel_x,
   output logic [YW-1:0] o_pixel_y,
   output logic [CW-1:0] o_color,
   output logic          o_set_pixel,
   input  logic          i_pixel_ready,
   output logic          o_err_opcode,
   output logic          o_err_timeout,
   output logic          o_err_range
);

   localparam int XB   = bytes_for(XW);
   localparam int YB   = bytes_for(YW);
   localparam int CB   = bytes_for(CW);
   localparam int MAXB = XB + YB + CB;
   localparam int CNTW = $clog2(MAXB + 1);

   localparam logic [CNTW-1:0] NEED_MODE  = CNTW'(1);
   localparam logic [CNTW-1:0] NEED_BG    = CNTW'(CB);
   localparam logic [CNTW-1:0] NEED_PIXEL = CNTW'(MAXB);

   // One extra bit so a limit equal to 2**width still compares correctly.
   localparam logic [XW:0] H_LIMIT = (XW+1)'(H_ACTIVE);
   localparam logic [YW:0] V_LIMIT = (YW+1)'(V_ACTIVE);

   state_t            state;
   logic [7:0]        cur_op;
   logic [CNTW-1:0]   needed;
   logic              accept;
   logic              in_args;
   logic              shift;
   logic              arg_full;
   logic              arg_timeout;
   logic [MAXB*8-1:0] arg_buf_next;
   logic [XW-1:0]     arg_x;
   logic [YW-1:0]     arg_y;
   logic [CW-1:0]     arg_color;
   logic [7:0]        arg_mode;
   logic              out_of_range;
   logic              unused_buf;

   assign accept  = i_en && i_we && ((state == ST_IDLE) || (state == ST_ARGS));
   assign in_args = (state == ST_ARGS);
   assign shift   = accept && in_args;

   // Field positions in the buffer as it looks once the final byte has shifted in;
   // colour occupies the top bytes for both SET_PIXEL and SET_BG_COLOR.
   assign arg_x        = arg_buf_next[XW-1:0];
   assign arg_y        = arg_buf_next[XB*8 +: YW];
   assign arg_color    = arg_buf_next[(XB+YB)*8 +: CW];
   assign arg_mode     = arg_buf_next[MAXB*8-8 +: 8];
   assign out_of_range = ({1'b0, arg_x} >= H_LIMIT) || ({1'b0, arg_y} >= V_LIMIT);
   assign unused_buf   = ^arg_buf_next;

   instruction_decoder_v2_collector #(
      .MAXB    (MAXB),
      .CNTW    (CNTW),
      .TIMEOUT (TIMEOUT)
   ) u_collector (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_active   (in_args),
      .i_shift    (shift),
      .i_data     (i_data),
      .i_needed   (needed),
      .o_full     (arg_full),
      .o_timeout  (arg_timeout),
      .o_buf_next (arg_buf_next)
   );

   // Decoder FSM with registered command, busy, ack and error outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= ST_IDLE;
         cur_op        <= '0;
         needed        <= '0;
         o_ack         <= 1'b0;
         o_busy        <= 1'b0;
         o_mode        <= '0;
         o_set_mode    <= 1'b0;
         o_pixel_x     <= '0;
         o_pixel_y     <= '0;
         o_color       <= '0;
         o_set_pixel   <= 1'b0;
         o_err_opcode  <= 1'b0;
         o_err_timeout <= 1'b0;
         o_err_range   <= 1'b0;
      end else begin
         o_ack         <= accept;
         o_err_opcode  <= 1'b0;
         o_err_timeout <= 1'b0;
         o_err_range   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (i_data)
                     OP_NOOP: ;
                     OP_SET_MODE: begin
                        cur_op <= i_data;
                        needed <= NEED_MODE;
                        state  <= ST_ARGS;
                        o_busy <= 1'b1;
                     end
                     OP_SET_BG_COLOR: begin
                        cur_op <= i_data;
                        needed <= NEED_BG;
                        state  <= ST_ARGS;
                        o_busy <= 1'b1;
                     end
                     OP_SET_PIXEL: begin
                        cur_op <= i_data;
                        needed <= NEED_PIXEL;
                        state  <= ST_ARGS;
                        o_busy <= 1'b1;
                     end
                     default: o_err_opcode <= 1'b1;
                  endcase
               end
            end
            ST_ARGS: begin
               if (arg_full) begin
                  if (cur_op == OP_SET_MODE) begin
                     o_mode     <= arg_mode;
                     o_set_mode <= 1'b1;
                     state      <= ST_ISSUE;
                  end else if (cur_op == OP_SET_BG_COLOR) begin
                     o_pixel_x   <= '0;
                     o_pixel_y   <= '0;
                     o_color     <= arg_color;
                     o_set_pixel <= 1'b1;
                     state       <= ST_ISSUE;
                  end else if (out_of_range) begin
                     o_err_range <= 1'b1;
                     state       <= ST_IDLE;
                     o_busy      <= 1'b0;
                  end else begin
                     o_pixel_x   <= arg_x;
                     o_pixel_y   <= arg_y;
                     o_color     <= arg_color;
                     o_set_pixel <= 1'b1;
                     state       <= ST_ISSUE;
                  end
               end else if (arg_timeout) begin
                  o_err_timeout <= 1'b1;
                  state         <= ST_IDLE;
                  o_busy        <= 1'b0;
               end
            end
            ST_ISSUE: begin
               if ((o_set_mode && i_mode_ready) || (o_set_pixel && i_pixel_ready)) begin
                  o_set_mode  <= 1'b0;
                  o_set_pixel <= 1'b0;
                  state       <= ST_IDLE;
                  o_busy      <= 1'b0;
               end
            end
            default: begin
               o_set_mode  <= 1'b0;
               o_set_pixel <= 1'b0;
               state       <= ST_IDLE;
               o_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_decoder_v2.sv
// Self-checking bench for instruction_decoder_v2: directed scenarios plus a
// randomized instruction stream checked against a byte-level decode model.
module tb_instruction_decoder_v2;

   localparam int TIMEOUT = 1024;

   localparam logic [2:0] EV_MODE = 3'd1;
   localparam logic [2:0] EV_PIX  = 3'd2;
   localparam logic [2:0] EV_EOP  = 3'd3;
   localparam logic [2:0] EV_ERNG = 3'd4;
   localparam logic [2:0] EV_ETO  = 3'd5;

   typedef struct packed {
      logic [2:0]  kind;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] c;
   } ev_t;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_we = 1'b0;
   logic        i_en = 1'b0;
   logic [7:0]  i_data = 8'h00;
   logic        i_mode_ready = 1'b1;
   logic        i_pixel_ready = 1'b1;
   logic        o_ack;
   logic        o_busy;
   logic [7:0]  o_mode;
   logic        o_set_mode;
   logic [9:0]  o_pixel_x;
   logic [9:0]  o_pixel_y;
   logic [11:0] o_color;
   logic        o_set_pixel;
   logic        o_err_opcode;
   logic        o_err_timeout;
   logic        o_err_range;
   logic [46:0] all_out;

   ev_t        obs_q[$];
   ev_t        exp_q[$];
   logic [7:0] stim_q[$];

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0;
   int mode_hi_cnt = 0;
   int excl_viol = 0;
   int stab_viol = 0;
   bit stream_done = 0;

   logic        prev_hold_pix = 1'b0;
   logic        prev_hold_mode = 1'b0;
   logic [31:0] prev_pix_data = '0;
   logic [7:0]  prev_mode = '0;

   instruction_decoder_v2 #(
      .XW       (10),
      .YW       (10),
      .CW       (12),
      .H_ACTIVE (640),
      .V_ACTIVE (480),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_we          (i_we),
      .i_en          (i_en),
      .i_data        (i_data),
      .o_ack         (o_ack),
      .o_busy        (o_busy),
      .o_mode        (o_mode),
      .o_set_mode    (o_set_mode),
      .i_mode_ready  (i_mode_ready),
      .o_pixel_x     (o_pixel_x),
      .o_pixel_y     (o_pixel_y),
      .o_color       (o_color),
      .o_set_pixel   (o_set_pixel),
      .i_pixel_ready (i_pixel_ready),
      .o_err_opcode  (o_err_opcode),
      .o_err_timeout (o_err_timeout),
      .o_err_range   (o_err_range)
   );

   assign all_out = {o_ack, o_busy, o_mode, o_set_mode, o_pixel_x, o_pixel_y, o_color,
                     o_set_pixel, o_err_opcode, o_err_timeout, o_err_range};

   always #5 i_clk = ~i_clk;

   function automatic ev_t mk_ev(input logic [2:0] k, input int px, input int py, input int pc);
      ev_t e;
      e.kind = k;
      e.x    = 10'(px);
      e.y    = 10'(py);
      e.c    = 12'(pc);
      return e;
   endfunction

   // Records completed transfers and error pulses, and watches the handshake rules.
   always @(negedge i_clk) begin
      if (!i_reset_n) begin
         prev_hold_pix  = 1'b0;
         prev_hold_mode = 1'b0;
      end else begin
         if (o_ack) ack_cnt++;
         if (o_set_mode) mode_hi_cnt++;
         if ($countones({o_err_opcode, o_err_timeout, o_err_range, (o_set_mode | o_set_pixel)}) > 1)
            excl_viol++;
         if (prev_hold_pix && (!o_set_pixel || ({o_pixel_x, o_pixel_y, o_color} != prev_pix_data)))
            stab_viol++;
         if (prev_hold_mode && (!o_set_mode || (o_mode != prev_mode)))
            stab_viol++;
         prev_hold_pix  = o_set_pixel && !i_pixel_ready;
         prev_pix_data  = {o_pixel_x, o_pixel_y, o_color};
         prev_hold_mode = o_set_mode && !i_mode_ready;
         prev_mode      = o_mode;
         if (o_set_mode && i_mode_ready) obs_q.push_back(mk_ev(EV_MODE, 0, 0, int'(o_mode)));
         if (o_set_pixel && i_pixel_ready)
            obs_q.push_back(mk_ev(EV_PIX, int'(o_pixel_x), int'(o_pixel_y), int'(o_color)));
         if (o_err_opcode)  obs_q.push_back(mk_ev(EV_EOP, 0, 0, 0));
         if (o_err_range)   obs_q.push_back(mk_ev(EV_ERNG, 0, 0, 0));
         if (o_err_timeout) obs_q.push_back(mk_ev(EV_ETO, 0, 0, 0));
      end
   end

   // Reference decode of a byte stream: opcode, then little-endian argument fields.
   function automatic void model_stream();
      int i = 0;
      int op, x, y, c;
      while (i < stim_q.size()) begin
         op = int'(stim_q[i]);
         i++;
         case (op)
            0: ;
            1: begin
               exp_q.push_back(mk_ev(EV_MODE, 0, 0, int'(stim_q[i])));
               i += 1;
            end
            2: begin
               c = (int'(stim_q[i]) + 256 * int'(stim_q[i+1])) % 4096;
               exp_q.push_back(mk_ev(EV_PIX, 0, 0, c));
               i += 2;
            end
            3: begin
               x = (int'(stim_q[i])   + 256 * int'(stim_q[i+1])) % 1024;
               y = (int'(stim_q[i+2]) + 256 * int'(stim_q[i+3])) % 1024;
               c = (int'(stim_q[i+4]) + 256 * int'(stim_q[i+5])) % 4096;
               if (x >= 640 || y >= 480) exp_q.push_back(mk_ev(EV_ERNG, 0, 0, 0));
               else                      exp_q.push_back(mk_ev(EV_PIX, x, y, c));
               i += 6;
            end
            default: exp_q.push_back(mk_ev(EV_EOP, 0, 0, 0));
         endcase
      end
   endfunction

   function automatic bit ev_match();
      if (obs_q.size() != exp_q.size()) return 1'b0;
      foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_queues();
      obs_q.delete();
      exp_q.delete();
      stim_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Presents one byte until the DUT acknowledges it; returns #1 after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      i_data = b;
      i_en   = 1'b1;
      i_we   = 1'b1;
      do begin
         @(posedge i_clk);
         #1;
         n++;
      end while (!o_ack && n < 300);
      i_en = 1'b0;
      i_we = 1'b0;
      if (!o_ack) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_byte: byte %h not acked after %0d cycles", b, n);
      end
   endtask

   task automatic send_stream();
      foreach (stim_q[i]) send_byte(stim_q[i]);
   endtask

   task automatic report_events(input string name);
      checks++;
      if (!ev_match()) begin
         errors++;
         $display("[TB] FAIL %s events: observed %0d, expected %0d", name, obs_q.size(), exp_q.size());
         foreach (obs_q[i]) $display("[TB]   observed[%0d] = %h", i, obs_q[i]);
         foreach (exp_q[i]) $display("[TB]   expected[%0d] = %h", i, exp_q[i]);
      end
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      #2;
      checks++;
      if (all_out !== 47'd0) begin
         errors++;
         $display("[TB] FAIL reset outputs: got %h, want 0", all_out);
      end
      repeat (2) @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      idle(2);
      checks++;
      if (all_out !== 47'd0) begin
         errors++;
         $display("[TB] FAIL post-reset idle outputs: got %h, want 0", all_out);
      end
   endtask

   task automatic test_set_mode();
      int a0, m0;
      clear_queues();
      i_mode_ready = 1'b1;
      a0 = ack_cnt;
      m0 = mode_hi_cnt;
      send_byte(8'h01);
      checks++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mode busy while collecting: got %b, want 1", o_busy);
      end
      send_byte(8'h07);
      checks++;
      if (o_set_mode !== 1'b1 || o_mode !== 8'h07) begin
         errors++;
         $display("[TB] FAIL mode latency: set_mode=%b mode=%h, want 1 07", o_set_mode, o_mode);
      end
      idle(4);
      checks++;
      if (ack_cnt - a0 !== 2) begin
         errors++;
         $display("[TB] FAIL mode ack count: got %0d, want 2", ack_cnt - a0);
      end
      checks++;
      if (mode_hi_cnt - m0 !== 1) begin
         errors++;
         $display("[TB] FAIL mode valid cycles: got %0d, want 1", mode_hi_cnt - m0);
      end
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mode busy after issue: got %b, want 0", o_busy);
      end
      exp_q.push_back(mk_ev(EV_MODE, 0, 0, 8'h07));
      report_events("set_mode");
   endtask

   task automatic test_set_pixel_backpressure();
      int s0;
      clear_queues();
      s0 = stab_viol;
      i_pixel_ready = 1'b0;
      stim_q = '{8'h03, 8'h7F, 8'h02, 8'hDF, 8'h01, 8'hAB, 8'h0C};
      send_stream();
      checks++;
      if (o_set_pixel !== 1'b1 || o_pixel_x !== 10'd639 || o_pixel_y !== 10'd479 || o_color !== 12'hCAB) begin
         errors++;
         $display("[TB] FAIL pixel latency: valid=%b x=%0d y=%0d c=%h, want 1 639 479 cab",
                  o_set_pixel, o_pixel_x, o_pixel_y, o_color);
      end
      i_data = 8'h00;
      i_en   = 1'b1;
      i_we   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge i_clk);
         #1;
         checks++;
         if (o_set_pixel !== 1'b1 || o_pixel_x !== 10'd639 || o_pixel_y !== 10'd479 ||
             o_color !== 12'hCAB || o_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pixel hold cycle %0d: valid=%b x=%0d y=%0d c=%h ack=%b, want 1 639 479 cab 0",
                     k, o_set_pixel, o_pixel_x, o_pixel_y, o_color, o_ack);
         end
      end
      i_pixel_ready = 1'b1;
      @(posedge i_clk);
      #1;
      checks++;
      if (o_set_pixel !== 1'b0 || o_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pixel transfer cycle: valid=%b ack=%b, want 0 0", o_set_pixel, o_ack);
      end
      @(posedge i_clk);
      #1;
      checks++;
      if (o_ack !== 1'b1) begin
         errors++;
         $display("[TB] FAIL held byte ack after issue: got %b, want 1", o_ack);
      end
      i_en = 1'b0;
      i_we = 1'b0;
      idle(3);
      checks++;
      if (stab_viol !== s0) begin
         errors++;
         $display("[TB] FAIL pixel stability: %0d violations, want 0", stab_viol - s0);
      end
      exp_q.push_back(mk_ev(EV_PIX, 639, 479, 12'hCAB));
      report_events("set_pixel");
   endtask

   task automatic test_range();
      clear_queues();
      i_pixel_ready = 1'b1;
      stim_q = '{8'h03, 8'h80, 8'h02, 8'h00, 8'h00, 8'hFF, 8'h0F};
      send_stream();
      checks++;
      if (o_err_range !== 1'b1 || o_set_pixel !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL range x=640: err=%b valid=%b busy=%b, want 1 0 0", o_err_range, o_set_pixel, o_busy);
      end
      idle(2);
      stim_q = '{8'h03, 8'h7F, 8'h02, 8'hE0, 8'h01, 8'h00, 8'h00};
      send_stream();
      checks++;
      if (o_err_range !== 1'b1 || o_set_pixel !== 1'b0) begin
         errors++;
         $display("[TB] FAIL range y=480: err=%b valid=%b, want 1 0", o_err_range, o_set_pixel);
      end
      idle(3);
      exp_q.push_back(mk_ev(EV_ERNG, 0, 0, 0));
      exp_q.push_back(mk_ev(EV_ERNG, 0, 0, 0));
      report_events("range");
   endtask

   task automatic test_bad_opcode_noop();
      int a0;
      clear_queues();
      send_byte(8'h5A);
      checks++;
      if (o_err_opcode !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bad opcode: err=%b busy=%b, want 1 0", o_err_opcode, o_busy);
      end
      stim_q = '{8'h02, 8'h34, 8'h01};
      send_stream();
      idle(2);
      a0 = ack_cnt;
      send_byte(8'h00);
      idle(3);
      checks++;
      if (ack_cnt - a0 !== 1 || o_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL noop: acks=%0d busy=%b, want 1 0", ack_cnt - a0, o_busy);
      end
      exp_q.push_back(mk_ev(EV_EOP, 0, 0, 0));
      exp_q.push_back(mk_ev(EV_PIX, 0, 0, 12'h134));
      report_events("opcode_noop");
   endtask

   task automatic test_timeout();
      int n;
      clear_queues();
      send_byte(8'h03);
      send_byte(8'h10);
      n = 0;
      do begin
         @(posedge i_clk);
         #1;
         n++;
      end while (!o_err_timeout && n < 2 * TIMEOUT);
      checks++;
      if (o_err_timeout !== 1'b1 || n !== TIMEOUT) begin
         errors++;
         $display("[TB] FAIL timeout delay: pulse=%b after %0d idle cycles, want 1 after %0d",
                  o_err_timeout, n, TIMEOUT);
      end
      send_byte(8'h01);
      send_byte(8'h02);
      idle(3);
      exp_q.push_back(mk_ev(EV_ETO, 0, 0, 0));
      exp_q.push_back(mk_ev(EV_MODE, 0, 0, 2));
      report_events("timeout");
      clear_queues();
      send_byte(8'h03);
      send_byte(8'h10);
      repeat (TIMEOUT - 1) @(posedge i_clk);
      #1;
      send_byte(8'h01);
      stim_q = '{8'h05, 8'h00, 8'h34, 8'h02};
      send_stream();
      idle(3);
      exp_q.push_back(mk_ev(EV_PIX, 272, 5, 12'h234));
      report_events("timeout_expiry_byte");
   endtask

   task automatic test_reset_mid();
      clear_queues();
      i_mode_ready = 1'b1;
      stim_q = '{8'h03, 8'h10, 8'h00};
      send_stream();
      #2;
      i_reset_n = 1'b0;
      #1;
      checks++;
      if (all_out !== 47'd0) begin
         errors++;
         $display("[TB] FAIL reset mid-args: outputs %h, want 0", all_out);
      end
      @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      send_byte(8'h01);
      send_byte(8'h05);
      idle(2);
      i_mode_ready = 1'b0;
      send_byte(8'h01);
      send_byte(8'h09);
      checks++;
      if (o_set_mode !== 1'b1 || o_mode !== 8'h09) begin
         errors++;
         $display("[TB] FAIL issue before reset: valid=%b mode=%h, want 1 09", o_set_mode, o_mode);
      end
      #2;
      i_reset_n = 1'b0;
      #1;
      checks++;
      if (all_out !== 47'd0) begin
         errors++;
         $display("[TB] FAIL reset mid-issue: outputs %h, want 0", all_out);
      end
      @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      i_mode_ready = 1'b1;
      idle(3);
      send_byte(8'h01);
      send_byte(8'h06);
      idle(3);
      exp_q.push_back(mk_ev(EV_MODE, 0, 0, 5));
      exp_q.push_back(mk_ev(EV_MODE, 0, 0, 6));
      report_events("reset_mid");
   endtask

   task automatic test_random();
      int k, x, y, a0;
      clear_queues();
      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 9);
         if (k == 0) begin
            stim_q.push_back(8'h00);
         end else if (k <= 2) begin
            stim_q.push_back(8'h01);
            stim_q.push_back(8'($urandom_range(0, 255)));
         end else if (k == 3) begin
            stim_q.push_back(8'h02);
            stim_q.push_back(8'($urandom_range(0, 255)));
            stim_q.push_back(8'($urandom_range(0, 255)));
         end else if (k <= 8) begin
            x = ($urandom_range(0, 1) == 1) ? $urandom_range(630, 645) : $urandom_range(0, 1023);
            y = ($urandom_range(0, 1) == 1) ? $urandom_range(470, 490) : $urandom_range(0, 1023);
            stim_q.push_back(8'h03);
            stim_q.push_back(8'(x));
            stim_q.push_back(8'((x >> 8) | ($urandom_range(0, 63) << 2)));
            stim_q.push_back(8'(y));
            stim_q.push_back(8'((y >> 8) | ($urandom_range(0, 63) << 2)));
            stim_q.push_back(8'($urandom_range(0, 255)));
            stim_q.push_back(8'($urandom_range(0, 255)));
         end else begin
            stim_q.push_back(8'($urandom_range(4, 255)));
         end
      end
      model_stream();
      a0 = ack_cnt;
      stream_done = 0;
      fork
         begin
            send_stream();
            stream_done = 1;
         end
         begin
            while (!stream_done) begin
               @(posedge i_clk);
               #1;
               i_mode_ready  = 1'($urandom_range(0, 1));
               i_pixel_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      i_mode_ready  = 1'b1;
      i_pixel_ready = 1'b1;
      idle(10);
      report_events("random");
      checks++;
      if (ack_cnt - a0 !== stim_q.size()) begin
         errors++;
         $display("[TB] FAIL random ack count: got %0d, want %0d", ack_cnt - a0, stim_q.size());
      end
      checks++;
      if (excl_viol !== 0) begin
         errors++;
         $display("[TB] FAIL exclusive pulses: %0d overlaps, want 0", excl_viol);
      end
      checks++;
      if (stab_viol !== 0) begin
         errors++;
         $display("[TB] FAIL valid stability: %0d violations, want 0", stab_viol);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_set_mode();
      test_set_pixel_backpressure();
      test_range();
      test_bad_opcode_noop();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
